// File: rtl/mccomp_trace_mon.sv
// rtl/mccomp_trace_mon.sv - multicycle CPU run monitor: fetch trace buffer, PC segment FIFO, halt/budget stop
module mccomp_trace_mon #(
    parameter int         WIDTH      = 32,
    parameter int         DEPTH      = 16,
    parameter int         SEG_DEPTH  = 8,
    parameter int         MAX_CYCLES = 275,
    parameter logic [2:0] FETCH_Q    = 3'b000,
    parameter int         STEP       = 4
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       en,
    input  logic [2:0]                 q,
    input  logic [WIDTH-1:0]           pc,
    input  logic [WIDTH-1:0]           ir,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [WIDTH-1:0]           rd_pc,
    output logic [WIDTH-1:0]           rd_ir,
    output logic [$clog2(DEPTH):0]     trace_cnt,
    output logic [31:0]                instr_cnt,
    output logic [31:0]                cycle_cnt,
    output logic                       seg_valid,
    output logic [WIDTH-1:0]           seg_start,
    output logic [WIDTH-1:0]           seg_end,
    input  logic                       seg_pop,
    output logic                       seg_ovf,
    output logic                       halt,
    output logic                       done
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(SEG_DEPTH);

    logic [2:0]       q_prev;
    logic [AW-1:0]    wp, wp_n, rd_addr;
    logic [AW:0]      cnt_n;
    logic [WIDTH-1:0] last_pc, cur_start, cur_end;
    logic             seg_open;
    logic [WIDTH-1:0] tr_pc [DEPTH];
    logic [WIDTH-1:0] tr_ir [DEPTH];
    logic [WIDTH-1:0] sf_start [SEG_DEPTH];
    logic [WIDTH-1:0] sf_end [SEG_DEPTH];
    logic [SW:0]      sf_wr, sf_rd;

    logic active, fetch, seq_hit, self_hit, budget_hit, set_done;
    logic rd_miss, rd_fwd;
    logic sf_empty, sf_full, do_pop, do_push, drop;
    logic push, nxt_open;
    logic [WIDTH-1:0] nxt_start, nxt_end, push_start, push_end;

    assign active     = en && !done;
    assign fetch      = active && (q == FETCH_Q) && (q_prev != FETCH_Q);
    assign seq_hit    = seg_open && (pc == last_pc + WIDTH'(STEP));
    assign self_hit   = seg_open && (pc == last_pc);
    assign budget_hit = active && (cycle_cnt + 32'd1 == 32'(MAX_CYCLES));
    assign set_done   = (fetch && self_hit) || budget_hit;

    // A break pushes the old segment; the done edge flushes whatever is open
    // afterwards, unless this cycle already used the single push slot.
    always_comb begin
        nxt_start  = cur_start;
        nxt_end    = cur_end;
        nxt_open   = seg_open;
        push       = 1'b0;
        push_start = cur_start;
        push_end   = cur_end;
        if (fetch) begin
            if (!seg_open) begin
                nxt_start = pc;
                nxt_end   = pc;
                nxt_open  = 1'b1;
            end else if (seq_hit) begin
                nxt_end = pc;
            end else if (!self_hit) begin
                push      = 1'b1;
                nxt_start = pc;
                nxt_end   = pc;
            end
        end
        if (set_done) begin
            if (!push && nxt_open) begin
                push       = 1'b1;
                push_start = nxt_start;
                push_end   = nxt_end;
            end
            nxt_open = 1'b0;
        end
    end

    assign sf_empty  = (sf_wr == sf_rd);
    assign sf_full   = ((sf_wr - sf_rd) == (SW+1)'(SEG_DEPTH));
    assign do_pop    = seg_pop && !sf_empty;
    assign do_push   = push && (!sf_full || do_pop);
    assign drop      = push && !do_push;
    assign seg_valid = !sf_empty;
    assign seg_start = seg_valid ? sf_start[sf_rd[SW-1:0]] : '0;
    assign seg_end   = seg_valid ? sf_end[sf_rd[SW-1:0]] : '0;

    // Read path looks at post-edge pointers and forwards the entry being written.
    assign cnt_n   = (fetch && trace_cnt != (AW+1)'(DEPTH)) ? trace_cnt + 1'b1 : trace_cnt;
    assign wp_n    = fetch ? wp + 1'b1 : wp;
    assign rd_addr = (cnt_n == (AW+1)'(DEPTH)) ? wp_n + rd_idx : rd_idx;
    assign rd_miss = ({1'b0, rd_idx} >= cnt_n);
    assign rd_fwd  = fetch && (rd_addr == wp);

    always_ff @(posedge clk) begin
        if (!clr && fetch) begin
            tr_pc[wp] <= pc;
            tr_ir[wp] <= ir;
        end
        if (!clr && do_push) begin
            sf_start[sf_wr[SW-1:0]] <= push_start;
            sf_end[sf_wr[SW-1:0]]   <= push_end;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_prev    <= 3'b111;
            wp        <= '0;
            trace_cnt <= '0;
            instr_cnt <= '0;
            cycle_cnt <= '0;
            last_pc   <= '0;
            cur_start <= '0;
            cur_end   <= '0;
            seg_open  <= 1'b0;
            sf_wr     <= '0;
            sf_rd     <= '0;
            seg_ovf   <= 1'b0;
            halt      <= 1'b0;
            done      <= 1'b0;
            rd_pc     <= '0;
            rd_ir     <= '0;
        end else begin
            q_prev    <= q;
            wp        <= wp_n;
            trace_cnt <= cnt_n;
            cur_start <= nxt_start;
            cur_end   <= nxt_end;
            seg_open  <= nxt_open;
            if (fetch) begin
                instr_cnt <= instr_cnt + 32'd1;
                last_pc   <= pc;
            end
            if (active)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (set_done)
                done <= 1'b1;
            if (fetch && self_hit)
                halt <= 1'b1;
            if (do_push)
                sf_wr <= sf_wr + 1'b1;
            if (do_pop)
                sf_rd <= sf_rd + 1'b1;
            if (drop)
                seg_ovf <= 1'b1;
            rd_pc <= rd_miss ? '0 : (rd_fwd ? pc : tr_pc[rd_addr]);
            rd_ir <= rd_miss ? '0 : (rd_fwd ? ir : tr_ir[rd_addr]);
        end
    end
endmodule

// File: tb/tb_mccomp_trace_mon.sv
// tb/tb_mccomp_trace_mon.sv - directed bench for mccomp_trace_mon (default, short-budget and 2-deep FIFO builds)
module tb_mccomp_trace_mon;
    logic        clk = 1'b0;
    logic        clr, en, seg_pop;
    logic [2:0]  q;
    logic [31:0] pc, ir;
    logic [3:0]  rd_idx;

    logic [31:0] m_rd_pc, m_rd_ir, m_instr_cnt, m_cycle_cnt, m_seg_start, m_seg_end;
    logic [4:0]  m_trace_cnt;
    logic        m_seg_valid, m_seg_ovf, m_halt, m_done;
    logic [31:0] b_rd_pc, b_rd_ir, b_instr_cnt, b_cycle_cnt, b_seg_start, b_seg_end;
    logic [4:0]  b_trace_cnt;
    logic        b_seg_valid, b_seg_ovf, b_halt, b_done;
    logic [31:0] s_rd_pc, s_rd_ir, s_instr_cnt, s_cycle_cnt, s_seg_start, s_seg_end;
    logic [4:0]  s_trace_cnt;
    logic        s_seg_valid, s_seg_ovf, s_halt, s_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mccomp_trace_mon u_main (
        .clk(clk), .clr(clr), .en(en), .q(q), .pc(pc), .ir(ir), .rd_idx(rd_idx),
        .rd_pc(m_rd_pc), .rd_ir(m_rd_ir), .trace_cnt(m_trace_cnt), .instr_cnt(m_instr_cnt),
        .cycle_cnt(m_cycle_cnt), .seg_valid(m_seg_valid), .seg_start(m_seg_start),
        .seg_end(m_seg_end), .seg_pop(seg_pop), .seg_ovf(m_seg_ovf), .halt(m_halt), .done(m_done)
    );

    mccomp_trace_mon #(.MAX_CYCLES(10)) u_bud (
        .clk(clk), .clr(clr), .en(en), .q(q), .pc(pc), .ir(ir), .rd_idx(rd_idx),
        .rd_pc(b_rd_pc), .rd_ir(b_rd_ir), .trace_cnt(b_trace_cnt), .instr_cnt(b_instr_cnt),
        .cycle_cnt(b_cycle_cnt), .seg_valid(b_seg_valid), .seg_start(b_seg_start),
        .seg_end(b_seg_end), .seg_pop(seg_pop), .seg_ovf(b_seg_ovf), .halt(b_halt), .done(b_done)
    );

    mccomp_trace_mon #(.SEG_DEPTH(2)) u_seg (
        .clk(clk), .clr(clr), .en(en), .q(q), .pc(pc), .ir(ir), .rd_idx(rd_idx),
        .rd_pc(s_rd_pc), .rd_ir(s_rd_ir), .trace_cnt(s_trace_cnt), .instr_cnt(s_instr_cnt),
        .cycle_cnt(s_cycle_cnt), .seg_valid(s_seg_valid), .seg_start(s_seg_start),
        .seg_end(s_seg_end), .seg_pop(seg_pop), .seg_ovf(s_seg_ovf), .halt(s_halt), .done(s_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr;
        clr = 1'b1;
        q   = 3'd1;
        cyc;
        clr = 1'b0;
    endtask

    // One instruction: fetch state for one cycle, then three other states.
    task automatic fetch(input logic [31:0] a, input logic p);
        q       = 3'd0;
        pc      = a;
        ir      = a ^ 32'hA5A5_0000;
        seg_pop = p;
        cyc;
        seg_pop = 1'b0;
        for (int k = 1; k < 4; k++) begin
            q = 3'(k);
            cyc;
        end
    endtask

    task automatic pop;
        seg_pop = 1'b1;
        cyc;
        seg_pop = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clr = 1'b1; en = 1'b1; q = 3'd1; pc = '0; ir = '0; rd_idx = '0; seg_pop = 1'b0;
        cyc;
        cyc;
        check("rst_trace_cnt", 32'(m_trace_cnt), 0);
        check("rst_instr_cnt", m_instr_cnt, 0);
        check("rst_cycle_cnt", m_cycle_cnt, 0);
        check("rst_seg_valid", 32'(m_seg_valid), 0);
        check("rst_seg_start", m_seg_start, 0);
        check("rst_rd_pc", m_rd_pc, 0);
        check("rst_done", 32'(m_done), 0);
        check("rst_ovf", 32'(m_seg_ovf), 0);
        clr = 1'b0;

        // Sequential run 0..28 broken by 40
        for (int i = 0; i < 8; i++) fetch(32'(i * 4), 1'b0);
        fetch(32'd40, 1'b0);
        check("t1_cycle_cnt", m_cycle_cnt, 36);
        check("t1_seg_valid", 32'(m_seg_valid), 1);
        check("t1_seg_start", m_seg_start, 0);
        check("t1_seg_end", m_seg_end, 28);
        check("t1_instr_cnt", m_instr_cnt, 9);
        check("t1_trace_cnt", 32'(m_trace_cnt), 9);
        rd_idx = 4'd8;
        cyc;
        check("t1_rd_pc8", m_rd_pc, 40);
        check("t1_rd_ir8", m_rd_ir, 32'hA5A5_0028);
        rd_idx = 4'd9;
        cyc;
        check("t1_rd_pc_oob", m_rd_pc, 0);

        // Trace wrap: 20 fetches into 16 entries
        do_clr;
        for (int i = 0; i < 20; i++) fetch(32'(i * 4), 1'b0);
        check("t2_trace_cnt", 32'(m_trace_cnt), 16);
        check("t2_instr_cnt", m_instr_cnt, 20);
        rd_idx = 4'd0;
        cyc;
        check("t2_rd_pc0", m_rd_pc, 16);
        rd_idx = 4'd15;
        cyc;
        check("t2_rd_pc15", m_rd_pc, 76);
        check("t2_rd_ir15", m_rd_ir, 32'hA5A5_004C);

        // Self-loop halt
        do_clr;
        fetch(32'd400, 1'b0);
        fetch(32'd404, 1'b0);
        fetch(32'd408, 1'b0);
        check("t3_halt_pre", 32'(m_halt), 0);
        fetch(32'd408, 1'b0);
        check("t3_halt", 32'(m_halt), 1);
        check("t3_done", 32'(m_done), 1);
        check("t3_seg_start", m_seg_start, 400);
        check("t3_seg_end", m_seg_end, 408);
        fetch(32'd500, 1'b0);
        check("t3_instr_frozen", m_instr_cnt, 4);
        check("t3_trace_frozen", 32'(m_trace_cnt), 4);
        check("t3_cycle_frozen", m_cycle_cnt, 13);
        rd_idx = 4'd3;
        cyc;
        check("t3_rd_pc3", m_rd_pc, 408);
        pop;
        check("t3_seg_valid_after_pop", 32'(m_seg_valid), 0);

        // Cycle budget of 10 with no fetches
        do_clr;
        repeat (9) cyc;
        check("t4_done_at9", 32'(b_done), 0);
        check("t4_cycle_at9", b_cycle_cnt, 9);
        cyc;
        check("t4_done_at10", 32'(b_done), 1);
        check("t4_cycle_at10", b_cycle_cnt, 10);
        repeat (3) cyc;
        check("t4_cycle_frozen", b_cycle_cnt, 10);
        check("t4_seg_valid", 32'(b_seg_valid), 0);
        check("t4_halt", 32'(b_halt), 0);

        // Two-deep FIFO overflow
        do_clr;
        fetch(32'd0, 1'b0);
        fetch(32'd40, 1'b0);
        fetch(32'd68, 1'b0);
        check("t5_ovf_pre", 32'(s_seg_ovf), 0);
        fetch(32'd408, 1'b0);
        check("t5_ovf", 32'(s_seg_ovf), 1);
        check("t5_head0", s_seg_start, 0);
        pop;
        check("t5_head1", s_seg_start, 40);
        pop;
        check("t5_empty", 32'(s_seg_valid), 0);

        // Same, with a pop on the full-push cycle
        do_clr;
        fetch(32'd0, 1'b0);
        fetch(32'd40, 1'b0);
        fetch(32'd68, 1'b0);
        fetch(32'd408, 1'b1);
        check("t5p_ovf", 32'(s_seg_ovf), 0);
        check("t5p_head0", s_seg_start, 40);
        pop;
        check("t5p_head1", s_seg_end, 68);

        // Clear mid-run
        do_clr;
        for (int i = 0; i < 5; i++) fetch(32'(i * 4), 1'b0);
        check("t6_instr_pre", m_instr_cnt, 5);
        clr = 1'b1;
        cyc;
        check("t6_trace_cnt", 32'(m_trace_cnt), 0);
        check("t6_instr_cnt", m_instr_cnt, 0);
        check("t6_cycle_cnt", m_cycle_cnt, 0);
        check("t6_rd_pc", m_rd_pc, 0);
        check("t6_seg_valid", 32'(m_seg_valid), 0);
        clr = 1'b0;
        fetch(32'd100, 1'b0);
        check("t6_trace_one", 32'(m_trace_cnt), 1);
        check("t6_seg_none", 32'(m_seg_valid), 0);
        fetch(32'd200, 1'b0);
        check("t6_seg_start", m_seg_start, 100);
        check("t6_seg_end", m_seg_end, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mccomp_trace_mon.md
# mccomp_trace_mon

Parametrised run monitor for the multicycle CPU. It watches the CPU state code `q`, `pc` and `ir` and records every instruction fetch in a circular trace buffer. It compresses the fetch stream into contiguous PC segments held in a small FIFO, and ends the run on a self-loop halt or a cycle budget. It sits beside the CPU core in simulation and FPGA builds, replacing fixed-length runs and hand-read PC ranges with a self-contained, readable record.

## Interface
Parameters:
- `WIDTH`, 32, PC/IR width
- `DEPTH`, 16, trace buffer entries (power of 2)
- `SEG_DEPTH`, 8, segment FIFO entries (power of 2)
- `MAX_CYCLES`, 275, cycle budget before forced `done`
- `FETCH_Q`, 3'b000, state code of the fetch state
- `STEP`, 4, sequential PC increment

Ports:
- `clk`  in  1  clock; all logic on the rising edge
- `clr`  in  1  reset; synchronous, active-high
- `en`  in  1  monitoring enable
- `q`  in  3  CPU state code
- `pc`  in  WIDTH  CPU program counter
- `ir`  in  WIDTH  CPU instruction register
- `rd_idx`  in  log2(DEPTH)  trace read index; 0 = oldest retained entry
- `rd_pc`, `rd_ir`  out  WIDTH  trace read data, registered
- `trace_cnt`  out  log2(DEPTH)+1  retained entries; saturates at DEPTH
- `instr_cnt`, `cycle_cnt`  out  32  fetch count, enabled-cycle count
- `seg_valid`  out  1  segment FIFO non-empty
- `seg_start`, `seg_end`  out  WIDTH  head segment's first and last fetched PC
- `seg_pop`  in  1  pop head segment; ignored when `!seg_valid`
- `seg_ovf`  out  1  sticky; a segment was dropped
- `halt`  out  1  sticky; self-loop detected
- `done`  out  1  sticky; run ended

## Operation
- `active` = `en && !done`.
- Fetch event: `active && q==FETCH_Q && q_prev!=FETCH_Q`.
  - `q_prev` is registered and resets to 3'b111.
  - Only the first cycle of a fetch-state run counts.
- On each fetch:
  - Write {pc, ir} at `wp`; `wp` wraps modulo DEPTH.
  - `instr_cnt`+1; `trace_cnt`+1, saturating at DEPTH.
  - `last_pc` <= pc.
- Read address = `rd_idx` while `trace_cnt<DEPTH`, else `(wp+rd_idx) mod DEPTH`.
- If `rd_idx >= trace_cnt`, then `rd_pc`=`rd_ir`=0.
- Segment tracker has an open segment {`cur_start`, `cur_end`} and an `open` flag.
  - First fetch with no segment open: `cur_start`=`cur_end`=pc, `open`=1.
  - `pc == last_pc+STEP` (WIDTH-bit wrap arithmetic): `cur_end`=pc.
  - Otherwise the open segment is pushed to the FIFO and a new one opens with start=end=pc.
- Halt: a fetch with `pc == last_pc` while `open` sets `halt`=1 and `done`=1. The halting fetch is still recorded in the trace.
- Budget: `cycle_cnt`+1 every `active` cycle. The edge on which `cycle_cnt` becomes MAX_CYCLES also sets `done`.
- Flush: the edge that sets `done` also pushes the open segment (if `open`) and clears `open`.
- FIFO push while full and no pop: the pushed segment is dropped and `seg_ovf`=1.
- FIFO push and pop in the same cycle:
  - Both take effect, including when the FIFO is full.
  - When empty, push takes effect and the pop is ignored.
- After `done`, no counter, trace or segment state changes. Pops continue to work.
- `clr` at any time, including mid-run or mid-pop, returns all state to reset. Buffer RAM need not clear; `trace_cnt`=0 masks it.

## Timing
- Reset values: all outputs 0. Internally `wp`, FIFO pointers and `open` are 0, `q_prev`=3'b111.
- A fetch sampled at edge t is reflected in `trace_cnt`, `instr_cnt` and `rd_*` after edge t.
- A segment push at edge t makes `seg_valid`=1 after edge t.
- `rd_pc`/`rd_ir` have a 1-cycle latency from `rd_idx`.
- `seg_start`/`seg_end` show the FIFO head combinationally from the registered FIFO.
- `seg_pop` at edge t advances the head after t.
- `halt`/`done` are high after the edge sampling the halting fetch or the budget-reaching cycle.

## Test plan
- Fetches at pc 0,4,…,28 then 40 (q cycling 0,1,2,3) -> after the 40 fetch, `seg_valid`=1 with {0,28}; `instr_cnt`=9.
- DEPTH=16, 20 sequential fetches pc 0..76 -> `trace_cnt`=16; rd_idx 0 gives `rd_pc`=16 one cycle later; rd_idx 15 gives 76.
- Fetches 400,404,408 then 408 again -> `halt`=`done`=1; FIFO holds {400,408}; further q activity changes nothing.
- MAX_CYCLES=10, en=1, no fetches -> `done`=1 with `cycle_cnt`=10; `seg_valid`=0.
- SEG_DEPTH=2, segments at 0, 40, 68, 408 with no pops -> `seg_ovf`=1 and the FIFO holds {0,..},{40,..}. Repeat with `seg_pop` on the full cycle -> no overflow.
- `clr` pulse mid-run after 5 fetches -> every output 0 on the next cycle; the next fetch opens a fresh segment and `trace_cnt`=1.
